// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode-class helpers for the sequential ALU.
// Used by seq_alu and seq_alu_muldiv.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SRA    = 5'b00110,
    OP_SUB    = 5'b00111,
    OP_EQ     = 5'b01000,
    OP_NE     = 5'b01001,
    OP_SLT    = 5'b01010,
    OP_SLTU   = 5'b01011,
    OP_GE     = 5'b01100,
    OP_GEU    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op[4:2] == 3'b101);
  endfunction

  function automatic logic op_signed_a(input logic [4:0] op);
    logic res;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_signed_b(input logic [4:0] op);
    logic res;
    case (op)
      OP_MULH, OP_DIV, OP_REM: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes,
// one bit per cycle, with sign correction applied to the final registers.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [W-1:0]   ZERO     = {W{1'b0}};
  localparam logic [2*W-1:0] ZERO2    = {(2*W){1'b0}};

  logic [4:0]    op_r;
  logic          neg_a_r;
  logic          neg_b_r;
  logic [W-1:0]  hi_r;
  logic [W-1:0]  lo_r;
  logic [W-1:0]  m_r;
  logic [CW-1:0] cnt_r;
  logic          run_r;
  logic          fix_r;

  logic          neg_a_s;
  logic          neg_b_s;
  logic [W-1:0]  mag_a_s;
  logic [W-1:0]  mag_b_s;
  logic [W:0]    mul_sum_s;
  logic [W:0]    div_shift_s;
  logic [W:0]    div_diff_s;
  logic [W-1:0]  hi_next_s;
  logic [W-1:0]  lo_next_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]  quo_s;
  logic [W-1:0]  rem_s;

  assign neg_a_s = op_signed_a(op) & a[W-1];
  assign neg_b_s = op_signed_b(op) & b[W-1];
  assign mag_a_s = neg_a_s ? (ZERO - a) : a;
  assign mag_b_s = neg_b_s ? (ZERO - b) : b;

  // hi/lo hold {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : {(W+1){1'b0}});
    div_shift_s = {hi_r, lo_r[W-1]};
    div_diff_s  = div_shift_s - {1'b0, m_r};
    if (is_div(op_r)) begin
      hi_next_s = div_diff_s[W] ? div_shift_s[W-1:0] : div_diff_s[W-1:0];
      lo_next_s = {lo_r[W-2:0], ~div_diff_s[W]};
    end else begin
      hi_next_s = mul_sum_s[W:1];
      lo_next_s = {mul_sum_s[0], lo_r[W-1:1]};
    end
  end

  assign prod_s = (neg_a_r ^ neg_b_r) ? (ZERO2 - {hi_r, lo_r}) : {hi_r, lo_r};
  assign quo_s  = (neg_a_r ^ neg_b_r) ? (ZERO - lo_r) : lo_r;
  assign rem_s  = neg_a_r ? (ZERO - hi_r) : hi_r;

  // Select the requested half/quotient/remainder after sign correction
  always_comb begin
    result = ZERO;
    case (op_r)
      OP_MUL:                       result = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:              result = quo_s;
      OP_REM, OP_REMU:              result = rem_s;
      default:                      result = ZERO;
    endcase
  end

  // Operand capture, iteration counter and phase flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 5'b00000;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      hi_r    <= ZERO;
      lo_r    <= ZERO;
      m_r     <= ZERO;
      cnt_r   <= {CW{1'b0}};
      run_r   <= 1'b0;
      fix_r   <= 1'b0;
    end else if (flush) begin
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b0;
      fix_r <= 1'b0;
    end else if (start) begin
      op_r    <= op;
      neg_a_r <= neg_a_s;
      neg_b_r <= neg_b_s;
      hi_r    <= ZERO;
      if (is_div(op)) begin
        lo_r <= mag_a_s;
        m_r  <= mag_b_s;
      end else begin
        lo_r <= mag_b_s;
        m_r  <= mag_a_s;
      end
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b1;
      fix_r <= 1'b0;
    end else if (run_r) begin
      hi_r  <= hi_next_s;
      lo_r  <= lo_next_s;
      cnt_r <= cnt_r + CNT_ONE;
      if (cnt_r == CNT_LAST) begin
        run_r <= 1'b0;
        fix_r <= 1'b1;
      end
    end else begin
      fix_r <= 1'b0;
    end
  end

  assign last = run_r & (cnt_r == CNT_LAST);
  assign done = fix_r;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle RV32 ALU with valid/ready handshake on both sides.
// Define SEQ_ALU_MULDIV_EN to add the iterative M-extension unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  alu_state_e            state_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] result_r;

  logic [4:0]            op_s;
  logic                  op_ok_s;
  logic [SHW-1:0]        shamt_s;
  logic [DATA_WIDTH-1:0] simple_res_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  muldiv_iter_s;
  logic                  mdu_last_s;
  logic                  mdu_done_s;
  logic [DATA_WIDTH-1:0] mdu_result_s;

  function automatic logic [DATA_WIDTH-1:0] flag_res(input logic f);
    return {{(DATA_WIDTH-1){1'b0}}, f};
  endfunction

  // Codes wider than the defined 5-bit space are treated as unknown ops
  assign op_s    = Operation[4:0];
  assign op_ok_s = ((Operation >> 3'd5) == {OPCODE_LENGTH{1'b0}});
  assign shamt_s = SrcB[SHW-1:0];

  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & OutReady);
  assign accept_s   = InValid & in_ready_s & ~Flush;

`ifdef SEQ_ALU_MULDIV_EN
  logic div_zero_s;
  logic div_ovf_s;

  assign div_zero_s    = (SrcB == ZERO);
  assign div_ovf_s     = (SrcA == MINV) & (SrcB == ONES) & op_signed_a(op_s);
  assign muldiv_iter_s = op_ok_s & is_muldiv(op_s) & ~(is_div(op_s) & (div_zero_s | div_ovf_s));

  seq_alu_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept_s & muldiv_iter_s),
    .flush  (Flush),
    .op     (op_s),
    .a      (SrcA),
    .b      (SrcB),
    .last   (mdu_last_s),
    .done   (mdu_done_s),
    .result (mdu_result_s)
  );
`else
  assign muldiv_iter_s = 1'b0;
  assign mdu_last_s    = 1'b0;
  assign mdu_done_s    = 1'b0;
  assign mdu_result_s  = ZERO;
`endif

  // Single-cycle results; divide special cases resolve here without iterating
  always_comb begin
    simple_res_s = ZERO;
    if (op_ok_s) begin
      case (op_s)
        OP_AND:  simple_res_s = SrcA & SrcB;
        OP_OR:   simple_res_s = SrcA | SrcB;
        OP_ADD:  simple_res_s = SrcA + SrcB;
        OP_XOR:  simple_res_s = SrcA ^ SrcB;
        OP_SLL:  simple_res_s = SrcA << shamt_s;
        OP_SRL:  simple_res_s = SrcA >> shamt_s;
        OP_SRA:  simple_res_s = $unsigned($signed(SrcA) >>> shamt_s);
        OP_SUB:  simple_res_s = SrcA - SrcB;
        OP_EQ:   simple_res_s = flag_res(SrcA == SrcB);
        OP_NE:   simple_res_s = flag_res(SrcA != SrcB);
        OP_SLT:  simple_res_s = flag_res($signed(SrcA) < $signed(SrcB));
        OP_SLTU: simple_res_s = flag_res(SrcA < SrcB);
        OP_GE:   simple_res_s = flag_res($signed(SrcA) >= $signed(SrcB));
        OP_GEU:  simple_res_s = flag_res(SrcA >= SrcB);
`ifdef SEQ_ALU_MULDIV_EN
        OP_DIV:  simple_res_s = div_zero_s ? ONES : MINV;
        OP_DIVU: simple_res_s = ONES;
        OP_REM:  simple_res_s = div_zero_s ? SrcA : ZERO;
        OP_REMU: simple_res_s = SrcA;
`endif
        default: simple_res_s = ZERO;
      endcase
    end else begin
      simple_res_s = ZERO;
    end
  end

  // Control FSM; flush outranks any same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      result_r    <= ZERO;
    end else if (Flush) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (muldiv_iter_s) begin
              state_r     <= CALC;
              out_valid_r <= 1'b0;
            end else begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= simple_res_s;
            end
          end else if ((state_r == DONE) && OutReady) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        CALC: begin
          if (mdu_last_s) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (mdu_done_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= mdu_result_s;
          end else begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign InReady   = in_ready_s;
  assign OutValid  = out_valid_r;
  assign ALUResult = result_r;

endmodule
